// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state encoding and statistics counter width for mem_access_unit
package mem_access_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_access_stat_counter.sv
// rtl/mem_access_stat_counter.sv - saturating event counter, holds at all-ones
module mem_access_stat_counter
    import mem_access_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit in front of a 1-cycle-latency data memory
// Optional load/store statistics counters: define MEM_ACCESS_STATS_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
`ifdef MEM_ACCESS_STATS_EN
    output logic [CNT_WIDTH-1:0]  load_count,
    output logic [CNT_WIDTH-1:0]  store_count,
`endif
    output logic                  busy
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_accept;

    assign w_accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next = req_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                mem_we = r_we;
                w_next = ST_IDLE;
            end
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  w_next = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Request fields stay frozen until the next acceptance so memory-side outputs never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == ST_WAIT) begin
                r_rdata <= mem_q;
            end
        end
    end

    assign mem_write_addr = r_addr;
    assign mem_read_addr  = r_addr;
    assign mem_data       = r_wdata;
    assign rsp_rdata      = r_rdata;

`ifdef MEM_ACCESS_STATS_EN
    mem_access_stat_counter #(.WIDTH(CNT_WIDTH)) u_load_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_accept && !req_we),
        .o_count (load_count)
    );

    mem_access_stat_counter #(.WIDTH(CNT_WIDTH)) u_store_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_accept && req_we),
        .o_count (store_count)
    );
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 31, word width of the data memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, word-address width of the data memory.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  request offered by the pipeline.
REQ-006 SHALL have port req_ready  out  1  unit accepts a request this cycle.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  in  ADDR_WIDTH  word address.
REQ-009 SHALL have port req_wdata  in  DATA_WIDTH  store data.
REQ-010 SHALL have port rsp_valid  out  1  load data available.
REQ-011 SHALL have port rsp_ready  in  1  consumer takes load data.
REQ-012 SHALL have port rsp_rdata  out  DATA_WIDTH  load data.
REQ-013 SHALL have ports mem_data (out, DATA_WIDTH), mem_read_addr (out, ADDR_WIDTH), mem_write_addr (out, ADDR_WIDTH), mem_we (out, 1) and mem_q (in, DATA_WIDTH), connecting to the data memory's synchronous write port and its read port with 1-cycle registered read latency.
REQ-014 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, WRITE, READ, WAIT and RESP.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a posedge with req_valid and req_ready both high.
REQ-017 SHALL, on acceptance, register req_we, req_addr and req_wdata, then go to WRITE if req_we = 1, else READ.
REQ-018 SHALL drive mem_write_addr, mem_read_addr and mem_data from the registered request at all times, so they are stable in every state.
REQ-019 SHALL assert mem_we only in WRITE, for exactly one cycle, then return to IDLE; stores produce no response.
REQ-020 SHALL advance READ -> WAIT unconditionally; the memory samples mem_read_addr at the end of READ.
REQ-021 SHALL capture mem_q into rsp_rdata at the end of WAIT, then go to RESP.
REQ-022 SHALL hold rsp_valid = 1 and rsp_rdata stable in RESP until rsp_ready = 1, then go to IDLE on that edge.
REQ-023 SHALL give a load latency of 3 cycles from the acceptance edge to the first cycle with rsp_valid = 1, and a store throughput of one per 2 cycles.
REQ-024 SHALL ignore req_valid while not in IDLE (no queuing); a request held with req_valid = 1 is accepted on the first IDLE edge.
REQ-025 SHALL return the new word for a load that immediately follows a store to the same address (the write completes before READ).

Reset
REQ-026 SHALL, on rst = 1, go to IDLE immediately and set rsp_valid = 0, rsp_rdata = 0, mem_we = 0, the request registers = 0 and busy = 0, so req_ready = 1 once rst is released.
REQ-027 SHALL drop a load in flight when rst is asserted, with no response after release, and a store in WRITE SHALL be aborted with mem_we forced to 0.

Configuration
REQ-028 SHALL, with macro MEM_ACCESS_STATS_EN defined, add outputs load_count and store_count (16 bits each), reset to 0 and incremented on each accepted load or store, saturating at 0xFFFF.
REQ-029 SHALL, without MEM_ACCESS_STATS_EN, omit these ports and counters, with all other behaviour unchanged.

Structure
REQ-030 SHALL place the state enum typedef and the counter width constant (16) in a shared package, mem_access_pkg.
REQ-031 SHALL implement the saturating counter as a sub-module, mem_access_stat_counter, instantiated twice under MEM_ACCESS_STATS_EN; no other sub-module is used.

Verification
REQ-032 SHALL cover a store to address 5 of 0x12345678 followed by a load of address 5 -> mem_we high for exactly 1 cycle; rsp_valid 3 cycles after acceptance with rsp_rdata = 0x12345678.
REQ-033 SHALL cover a load with rsp_ready held low for 4 cycles -> rsp_valid and rsp_rdata stable for all 4 cycles, req_ready = 0 throughout, and IDLE on the edge after rsp_ready = 1.
REQ-034 SHALL cover req_valid held high for 3 back-to-back stores -> accepted on every other edge, with addresses 0, 1, 2 written in order.
REQ-035 SHALL cover rst asserted during WAIT -> rsp_valid never rises and busy = 0 immediately; the next load then returns correct data.
REQ-036 SHALL cover, with MEM_ACCESS_STATS_EN, 2 loads and 3 stores -> load_count = 2 and store_count = 3; with store_count preset near 0xFFFF, it saturates at 0xFFFF.
